// File: rtl/am_demod_iter_pkg.sv
// Shared definitions for the AM envelope detector and its square-root core.
//  - FSM state encoding
//  - saturation-limit helper for the signed output range
package am_demod_iter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQR  = 3'd1,
    ST_SUM  = 3'd2,
    ST_ROOT = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  // Largest positive value of an n-bit two's complement word.
  function automatic int sat_limit(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

endpackage

// File: rtl/am_demod_iter_sqrt.sv
// sqrt_iter: restoring integer square root, MSB first, one root bit per clock.
//  clk, reset_n : clock, async active-low reset
//  start        : load radical and resolve the first root bit on this edge
//  radical      : 2*N-bit unsigned operand (sampled only with start)
//  done         : high for one cycle once root holds the final floor(sqrt)
//  root         : N-bit unsigned result
// A start edge performs iteration 1, so done is high in the N-th cycle
// after the start cycle.
module sqrt_iter #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [2*N-1:0] radical,
  output logic           done,
  output logic [N-1:0]   root
);

  // Partial remainder never exceeds 2*root, so N+2 bits are enough.
  localparam int RW = N + 2;
  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] rad_q, rad_s, rad_n;
  logic [RW-1:0]  rem_q, rem_s, rem_n;
  logic [N-1:0]   root_s, root_n;
  logic [RW+1:0]  rem_sh, trial;
  logic           ge;
  logic [CW-1:0]  cnt_q;

  // One iteration; on start it operates on the fresh operand.
  always_comb begin
    rad_s  = start ? radical : rad_q;
    rem_s  = start ? '0 : rem_q;
    root_s = start ? '0 : root;
    rem_sh = {rem_s, rad_s[2*N-1:2*N-2]};
    trial  = {2'b00, root_s, 2'b01};
    ge     = (rem_sh >= trial);
    rem_n  = ge ? (rem_sh[RW-1:0] - trial[RW-1:0]) : rem_sh[RW-1:0];
    root_n = {root_s[N-2:0], ge};
    rad_n  = {rad_s[2*N-3:0], 2'b00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rad_q <= '0;
      rem_q <= '0;
      root  <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
    end else if (start || cnt_q != '0) begin
      rad_q <= rad_n;
      rem_q <= rem_n;
      root  <= root_n;
      cnt_q <= start ? CW'(N - 1) : cnt_q - 1'b1;
      done  <= start ? (N == 1) : (cnt_q == CW'(1));
    end else begin
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/am_demod_iter.sv
// am_demod_iter: multi-channel AM envelope detector,
//   data_out = sqrt((i^2 + q^2 + 1) >> 1), saturated, optional per-channel DC removal.
//  clk, reset_n       : clock, async active-low reset
//  strobe_in, ch_in   : sample valid pulse and channel tag
//  i_in, q_in         : signed I/Q sample
//  dc_block_en        : subtract tracked per-channel DC from the magnitude
//  ready              : high in IDLE only; a strobe_in is accepted only then
//  strobe_out, ch_out : one-cycle result pulse and its channel tag
//  data_out           : signed envelope (held between strobes)
//  overrun            : sticky, set when strobe_in arrives while busy
// Sample flow: IDLE(capture) -> SQR -> SUM -> ROOT x DATA_SIZE -> OUT.
// The result registers load on the ROOT->OUT edge, so strobe_out and
// data_out are both valid during the OUT cycle.
module am_demod_iter
  import am_demod_iter_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int NUM_CH    = 2,
  parameter int CH_W      = 1,
  parameter int DC_SHIFT  = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 strobe_in,
  input  logic [CH_W-1:0]      ch_in,
  input  logic [DATA_SIZE-1:0] i_in,
  input  logic [DATA_SIZE-1:0] q_in,
  input  logic                 dc_block_en,
  output logic                 ready,
  output logic                 strobe_out,
  output logic [CH_W-1:0]      ch_out,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 overrun
);

  localparam int N  = DATA_SIZE;
  localparam int AW = DATA_SIZE + DC_SHIFT;
  localparam logic [N-1:0] MAG_MAX = N'(sat_limit(N));
  localparam logic [N-1:0] OUT_MIN = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [N:0] DIFF_MIN = {2'b11, {(N-1){1'b0}}};

  if ((2 ** CH_W) < NUM_CH) begin : g_ch_w_check
    $error("CH_W too narrow for NUM_CH");
  end

  state_t state_q, state_d;

  logic signed [N-1:0]    i_q, q_q;
  logic [CH_W-1:0]        ch_q;
  logic [2*N-1:0]         i2_q, q2_q, radical;
  logic [N-1:0]           root;
  logic                   root_done;
  logic                   ch_ok;
  logic [NUM_CH-1:0][AW-1:0] acc_q;

  logic [AW-1:0]          acc_cur, acc_nxt;
  logic [N-1:0]           mag, dc, data_n;
  logic signed [N:0]      diff;

  assign ch_ok = (int'(ch_in) < NUM_CH);
  assign ready = (state_q == ST_IDLE);
  assign strobe_out = (state_q == ST_OUT);

  // (a + b + 1) >> 1 without a wider adder: halve each square and round up
  // when either is odd (never both odd-and-carrying beyond one unit).
  assign radical = (i2_q >> 1) + (q2_q >> 1) + {{(2*N-1){1'b0}}, i2_q[0] | q2_q[0]};

  sqrt_iter #(.N(N)) u_sqrt (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (state_q == ST_SUM),
    .radical (radical),
    .done    (root_done),
    .root    (root)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (strobe_in && ch_ok) state_d = ST_SQR;
      ST_SQR:  state_d = ST_SUM;
      ST_SUM:  state_d = ST_ROOT;
      ST_ROOT: if (root_done) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Output formation: saturate the root, then optional DC subtraction.
  // The accumulator never drops below dc << DC_SHIFT, so acc + mag - dc
  // cannot underflow.
  always_comb begin
    acc_cur = acc_q[ch_q];
    mag     = (root > MAG_MAX) ? MAG_MAX : root;
    dc      = acc_cur[AW-1:DC_SHIFT];
    diff    = $signed({1'b0, mag}) - $signed({1'b0, dc});
    acc_nxt = acc_cur + AW'(mag) - AW'(dc);
    data_n  = mag;
    if (dc_block_en) data_n = (diff < DIFF_MIN) ? OUT_MIN : diff[N-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q      <= '0;
      q_q      <= '0;
      ch_q     <= '0;
      i2_q     <= '0;
      q2_q     <= '0;
      ch_out   <= '0;
      data_out <= '0;
      overrun  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      if (strobe_in && state_q != ST_IDLE) overrun <= 1'b1;
      if (state_q == ST_IDLE && strobe_in && ch_ok) begin
        i_q  <= i_in;
        q_q  <= q_in;
        ch_q <= ch_in;
      end
      if (state_q == ST_SQR) begin
        i2_q <= i_q * i_q;
        q2_q <= q_q * q_q;
      end
      if (state_q == ST_ROOT && root_done) begin
        data_out <= data_n;
        ch_out   <= ch_q;
        if (dc_block_en) acc_q[ch_q] <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_am_demod_iter.sv
module tb_am_demod_iter;

  localparam int N  = 16;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int DS = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          strobe_in = 1'b0;
  logic [CW-1:0] ch_in = '0;
  logic [N-1:0]  i_in = '0, q_in = '0;
  logic          dc_block_en = 1'b0;
  logic          ready, strobe_out, overrun;
  logic [CW-1:0] ch_out;
  logic [N-1:0]  data_out;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  am_demod_iter #(.DATA_SIZE(N), .NUM_CH(NC), .CH_W(CW), .DC_SHIFT(DS)) dut (
    .clk(clk), .reset_n(reset_n), .strobe_in(strobe_in), .ch_in(ch_in),
    .i_in(i_in), .q_in(q_in), .dc_block_en(dc_block_en), .ready(ready),
    .strobe_out(strobe_out), .ch_out(ch_out), .data_out(data_out), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample in IDLE, wait (bounded) for strobe_out, return data and latency.
  task automatic run(input logic [CW-1:0] ch, input int i, input int q,
                     output int d, output int lat);
    @(posedge clk); #1;
    chk("ready_before", ready, 1);
    strobe_in = 1'b1; ch_in = ch; i_in = N'(i); q_in = N'(q);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) strobe_in = 1'b0;
      if (strobe_out) begin lat = k; break; end
    end
    d = int'($signed(data_out));
    @(posedge clk); #1;
    chk("strobe_pulse_width", strobe_out, 0);
  endtask

  task automatic run_chk(input string tag, input logic [CW-1:0] ch, input int i, input int q,
                         input int exp);
    int d, lat;
    run(ch, i, q, d, lat);
    chk({tag, "_lat"}, lat, 19);
    chk({tag, "_data"}, d, exp);
    chk({tag, "_ch"}, ch_out, ch);
  endtask

  initial begin
    int d, lat, cnt, first_k, second_k, first_d, second_d;
    int prev0, prev1;

    // Reset state
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_strobe", strobe_out, 0);
    chk("rst_ch", ch_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Raw magnitude, hand-computed
    run_chk("i1000", 0, 1000, 0, 707);
    repeat (3) @(posedge clk);
    #1 chk("hold_data", $signed(data_out), 707);
    run_chk("fullscale_sat", 1, -32768, -32768, 32767);
    run_chk("zero", 2, 0, 0, 0);
    run_chk("i3q4", 0, 3, 4, 3);
    run_chk("im3qm4", 1, -3, -4, 3);
    run_chk("i32767", 0, 32767, 0, 23169);

    // Out-of-range channel tag is ignored silently
    @(posedge clk); #1;
    strobe_in = 1'b1; ch_in = 2'd3; i_in = N'(1000); q_in = '0;
    @(posedge clk); #1;
    strobe_in = 1'b0;
    chk("badch_ready", ready, 1);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (strobe_out) cnt++;
    end
    chk("badch_no_strobe", cnt, 0);
    chk("badch_overrun", overrun, 0);
    chk("badch_hold_data", $signed(data_out), 23169);

    // Overrun: strobe at +5 dropped, strobe at +20 accepted
    @(posedge clk); #1;
    strobe_in = 1'b1; ch_in = 2'd0; i_in = N'(1000); q_in = '0;
    cnt = 0; first_k = -1; second_k = -1; first_d = -1; second_d = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      strobe_in = 1'b0;
      if (k == 5)  begin strobe_in = 1'b1; ch_in = 2'd1; i_in = N'(3); q_in = N'(4); end
      if (k == 20) begin strobe_in = 1'b1; ch_in = 2'd2; i_in = N'(200); q_in = N'(200); end
      if (strobe_out) begin
        cnt++;
        if (cnt == 1) begin first_k = k; first_d = int'($signed(data_out)); end
        if (cnt == 2) begin second_k = k; second_d = int'($signed(data_out)); end
      end
    end
    chk("ovr_flag", overrun, 1);
    chk("ovr_strobe_count", cnt, 2);
    chk("ovr_first_lat", first_k, 19);
    chk("ovr_first_data", first_d, 707);
    chk("ovr_second_lat", second_k, 39);
    chk("ovr_second_data", second_d, 200);
    chk("ovr_second_ch", ch_out, 2);
    run_chk("ovr_after", 0, 3, 4, 3);
    chk("ovr_sticky", overrun, 1);

    // DC block: ch1 alone first, then interleaved with ch0
    dc_block_en = 1'b1;
    prev1 = 100000; prev0 = 100000;
    for (int s = 0; s < 8; s++) begin
      run(1, 1000, 1000, d, lat);
      if (s == 0) chk("dc_ch1_first", d, 1000);
      chk("dc_ch1_mono", (d <= prev1), 1);
      prev1 = d;
    end
    for (int s = 0; s < 512; s++) begin
      run(1, 1000, 1000, d, lat);
      chk("dc_ch1_mono", (d <= prev1), 1);
      prev1 = d;
      run(0, 200, 200, d, lat);
      if (s == 0) chk("dc_ch0_independent", d, 200);
      chk("dc_ch0_mono", (d <= prev0), 1);
      prev0 = d;
    end
    chk("dc_ch1_settled", (prev1 >= -2 && prev1 <= 2), 1);
    chk("dc_ch0_settled", (prev0 >= -2 && prev0 <= 2), 1);

    // Disabled: raw magnitude, accumulators held
    dc_block_en = 1'b0;
    run_chk("dc_off_raw", 1, 1000, 1000, 1000);
    dc_block_en = 1'b1;
    run(1, 1000, 1000, d, lat);
    chk("dc_acc_held", (d >= -2 && d <= 2), 1);
    dc_block_en = 1'b0;
    chk("ovr_still_sticky", overrun, 1);

    // Reset in ROOT abandons the sample
    run_chk("pre_rst", 2, 1000, 0, 707);
    @(posedge clk); #1;
    strobe_in = 1'b1; ch_in = 2'd1; i_in = N'(1000); q_in = '0;
    @(posedge clk); #1;
    strobe_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_data", data_out, 0);
    chk("midrst_ch", ch_out, 0);
    chk("midrst_strobe", strobe_out, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_ready", ready, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (strobe_out) cnt++;
    end
    chk("midrst_no_strobe", cnt, 0);
    run_chk("post_rst", 1, 3, 4, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
